// File: rtl/ps2_sprite_mover_if.sv
// ps2_sprite_mover_if: PS/2 byte input, vsync and sprite position/key outputs
interface ps2_sprite_mover_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       iVS;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [3:0] oKeys;
  logic       oMoving;
  modport master (output ps2_key_pressed, ps2_out, iVS, input oX, oY, oKeys, oMoving);
  modport slave  (input ps2_key_pressed, ps2_out, iVS, output oX, oY, oKeys, oMoving);
endinterface

// File: rtl/ps2_sprite_mover.sv
// ps2_sprite_mover: decodes W/A/S/D make/break scancodes and moves a clamped sprite once per frame
module ps2_sprite_mover #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPR_W    = 30,
  parameter int SPR_H    = 30,
  parameter int STEP     = 2,
  parameter int X_INIT   = 340,
  parameter int Y_INIT   = 200
) (
  input logic iVGA_CLK,
  input logic reset,
  ps2_sprite_mover_if.slave bus
);
  localparam int XMAX = SCREEN_W - SPR_W;
  localparam int YMAX = SCREEN_H - SPR_H;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} state_t;
  state_t      state_q;
  logic [2:0]  kp_q;
  logic [1:0]  vs_q;
  logic [3:0]  keys_q;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        moving_q;
  logic        byte_ev, tick;
  logic [3:0]  hit;
  logic [10:0] x_dec, x_inc;
  logic [9:0]  y_dec, y_inc;
  assign byte_ev = kp_q[1] & ~kp_q[2];
  assign tick    = vs_q[1] & ~vs_q[0];
  assign hit     = {bus.ps2_out == 8'h1D, bus.ps2_out == 8'h1B, bus.ps2_out == 8'h1C, bus.ps2_out == 8'h23};
  // next position: widened arithmetic so underflow shows up in the top bit and is clamped to 0
  always_comb begin
    x_dec = {1'b0, x_q} - 11'(STEP);
    x_inc = {1'b0, x_q} + 11'(STEP);
    y_dec = {1'b0, y_q} - 10'(STEP);
    y_inc = {1'b0, y_q} + 10'(STEP);
    x_d = (keys_q[1] & ~keys_q[0]) ? (x_dec[10] ? 10'd0 : x_dec[9:0]) :
          (keys_q[0] & ~keys_q[1]) ? (x_inc > 11'(XMAX) ? 10'(XMAX) : x_inc[9:0]) : x_q;
    y_d = (keys_q[3] & ~keys_q[2]) ? (y_dec[9] ? 9'd0 : y_dec[8:0]) :
          (keys_q[2] & ~keys_q[3]) ? (y_inc > 10'(YMAX) ? 9'(YMAX) : y_inc[8:0]) : y_q;
  end
  // synchronize the byte-valid level and register vsync for edge detection
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      kp_q <= '0;
      vs_q <= '0;
    end else begin
      kp_q <= {kp_q[1:0], bus.ps2_key_pressed};
      vs_q <= {vs_q[0], bus.iVS};
    end
  end
  // make/break decoder; extended (E0) sequences are swallowed without touching keys
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      keys_q  <= '0;
    end else if (byte_ev) begin
      case (state_q)
        IDLE: begin
          state_q <= bus.ps2_out == 8'hF0 ? BRK : bus.ps2_out == 8'hE0 ? EXT : IDLE;
          keys_q  <= keys_q | hit;
        end
        BRK: begin
          state_q <= IDLE;
          keys_q  <= keys_q & ~hit;
        end
        EXT:     state_q <= bus.ps2_out == 8'hF0 ? EXTBRK : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // position only updates on the frame tick, using keys held before any same-cycle byte
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      x_q      <= 10'(X_INIT);
      y_q      <= 9'(Y_INIT);
      moving_q <= 1'b0;
    end else begin
      x_q      <= tick ? x_d : x_q;
      y_q      <= tick ? y_d : y_q;
      moving_q <= tick && (x_d != x_q || y_d != y_q);
    end
  end
  assign bus.oX      = x_q;
  assign bus.oY      = y_q;
  assign bus.oKeys   = keys_q;
  assign bus.oMoving = moving_q;
endmodule

// File: tb/tb_ps2_sprite_mover.sv
// tb_ps2_sprite_mover: directed and random scancode/frame stimulus against a behavioural model
module tb_ps2_sprite_mover;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mov_cnt = 0;
  int   mx, my;
  bit   emov;
  logic [3:0] mk;
  logic [7:0] pend[$];
  ps2_sprite_mover_if bus ();
  ps2_sprite_mover dut (.iVGA_CLK(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.oMoving === 1'b1) mov_cnt++;
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic int kidx(logic [7:0] b);
    return b == 8'h1D ? 3 : b == 8'h1B ? 2 : b == 8'h1C ? 1 : b == 8'h23 ? 0 : -1;
  endfunction
  task automatic model_byte(logic [7:0] b);
    int k = kidx(b);
    if (pend.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
      else if (k >= 0) mk[k] = 1'b1;
    end else if (pend[0] == 8'hE0) begin
      if (pend.size() == 1 && b == 8'hF0) pend.push_back(b);
      else pend.delete();
    end else begin
      if (k >= 0) mk[k] = 1'b0;
      pend.delete();
    end
  endtask
  task automatic model_tick();
    int nx = mx, ny = my;
    if (mk[1] && !mk[0]) nx = (mx - 2 < 0) ? 0 : mx - 2;
    if (mk[0] && !mk[1]) nx = (mx + 2 > 610) ? 610 : mx + 2;
    if (mk[3] && !mk[2]) ny = (my - 2 < 0) ? 0 : my - 2;
    if (mk[2] && !mk[3]) ny = (my + 2 > 450) ? 450 : my + 2;
    emov = (nx != mx) || (ny != my);
    mx = nx;
    my = ny;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.ps2_key_pressed = 1'b0;
    bus.iVS = 1'b1;
    cyc(3);
    reset = 1'b0;
    mx = 340; my = 200; mk = '0; pend.delete();
    cyc(1);
  endtask
  task automatic send(logic [7:0] b);
    model_byte(b);
    bus.ps2_out = b;
    bus.ps2_key_pressed = 1'b1;
    cyc(4);
    chk("keys", 32'(bus.oKeys), 32'(mk));
    bus.ps2_key_pressed = 1'b0;
    cyc(3);
  endtask
  task automatic frame();
    int c0 = mov_cnt;
    model_tick();
    bus.iVS = 1'b0;
    cyc(3);
    chk("x", 32'(bus.oX), 32'(mx));
    chk("y", 32'(bus.oY), 32'(my));
    bus.iVS = 1'b1;
    cyc(2);
    chk("moving", 32'(mov_cnt - c0), 32'(emov));
  endtask
  initial begin
    logic [7:0] tbl [7];
    int c0;
    tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hF0, 8'hE0, 8'h29};
    bus.ps2_out = 8'h00;
    do_reset();
    chk("rst_x", 32'(bus.oX), 32'd340);
    chk("rst_y", 32'(bus.oY), 32'd200);
    chk("rst_keys", 32'(bus.oKeys), 32'd0);
    chk("rst_mov", 32'(bus.oMoving), 32'd0);
    send(8'h1C);
    chk("a_held", 32'(bus.oKeys), 32'b0010);
    repeat (10) frame();
    chk("x_after_10", 32'(bus.oX), 32'd320);
    send(8'hF0); send(8'h1C);
    frame();
    chk("x_frozen", 32'(bus.oX), 32'd320);
    send(8'h23);
    for (int i = 0; i < 400 && mx < 608; i++) frame();
    chk("x_608", 32'(bus.oX), 32'd608);
    repeat (3) frame();
    chk("x_clamp", 32'(bus.oX), 32'd610);
    send(8'hF0); send(8'h23);
    send(8'h1D);
    for (int i = 0; i < 300 && my > 0; i++) frame();
    frame();
    chk("y_floor", 32'(bus.oY), 32'd0);
    send(8'hF0); send(8'h1D);
    send(8'h1C); send(8'h23);
    chk("ad_keys", 32'(bus.oKeys), 32'b0011);
    repeat (5) frame();
    chk("ad_x", 32'(bus.oX), 32'd610);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
    send(8'hE0); send(8'hF0); send(8'h1C);
    chk("ext_ignored", 32'(bus.oKeys), 32'd0);
    send(8'h1C);
    chk("a_after_ext", 32'(bus.oKeys), 32'b0010);
    c0 = mov_cnt;
    model_tick();
    model_byte(8'h23);
    bus.ps2_out = 8'h23;
    bus.ps2_key_pressed = 1'b1;
    cyc(1);
    bus.iVS = 1'b0;
    cyc(3);
    chk("same_cyc_x", 32'(bus.oX), 32'(mx));
    chk("same_cyc_keys", 32'(bus.oKeys), 32'b0011);
    bus.ps2_key_pressed = 1'b0;
    bus.iVS = 1'b1;
    cyc(3);
    chk("same_cyc_mov", 32'(mov_cnt - c0), 32'(emov));
    send(8'hF0);
    do_reset();
    chk("rst2_x", 32'(bus.oX), 32'd340);
    chk("rst2_y", 32'(bus.oY), 32'd200);
    chk("rst2_keys", 32'(bus.oKeys), 32'd0);
    send(8'h1C);
    chk("fresh_decode", 32'(bus.oKeys), 32'b0010);
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) frame();
      else if (r < 9) send(tbl[$urandom_range(0, 6)]);
      else send(8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
